neuron_accumulator: RTL and testbench
=====================================

Name: neuron_accumulator

Overview:
Upstream stage of activation_function in the single-layer perceptron. Accepts a stream of N_INPUTS (input, weight) pairs in 17.15 signed fixed point and forms bias + sum(x_i * w_i). Delivers the saturated 32-bit 17.15 result over a valid/ready handshake, directly as the x operand of activation_function. One neuron evaluation per start pulse.

Parameters:
N_INPUTS, 4, number of (x, w) pairs per evaluation; must be >= 1
DATA_W, 32, width of x, w, bias and sum (17.15 signed)
FRAC_BITS, 15, fractional bits; fixed-point 1.0 = 1 << FRAC_BITS = 32768
ACC_W, 56, internal accumulator width; must be >= 2*DATA_W-FRAC_BITS+1+clog2(N_INPUTS+1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin an evaluation; sampled only in IDLE
bias  in  DATA_W  signed bias, captured on accepted start
busy  out  1  high in ACCUM and DONE
in_valid  in  1  x_in/w_in valid
in_ready  out  1  pair accepted when in_valid & in_ready
x_in  in  DATA_W  signed input sample
w_in  in  DATA_W  signed weight
sum_valid  out  1  sum_out valid
sum_ready  in  1  consumer accepts sum_out
sum_out  out  DATA_W  signed saturated weighted sum

Behaviour:
- Reset (rst_n low at clk edge): state=IDLE, acc=0, count=0, sum_out=0, sum_valid=0, busy=0, in_ready=0. Reset at any point aborts the evaluation with no partial result.
- FSM: IDLE -> ACCUM on start; ACCUM -> DONE on the handshake of pair N_INPUTS-1; DONE -> IDLE on sum_valid & sum_ready.
- IDLE: in_ready=0. On start: acc <= sign-extended bias, count <= 0. start outside IDLE is ignored. A pair presented in the start cycle is not accepted.
- ACCUM: in_ready=1 combinationally from state only, not dependent on in_valid. Each handshake: p = (x_in * w_in), full 2*DATA_W signed product, then arithmetic right shift by FRAC_BITS (truncate toward -inf). Then acc <= acc + sign-extended p, count <= count+1. Cycles without in_valid leave state unchanged. No timeout.
- On the final handshake, sum_out <= sat(acc + p) and sum_valid <= 1 on the same edge. Latency is 1 cycle from the last accepted pair to sum_valid.
- sat(): if value > 2^(DATA_W-1)-1 -> 0x7FFFFFFF; if value < -2^(DATA_W-1) -> 0x80000000; otherwise truncate to DATA_W. Saturation is applied at the output only; intermediate acc never wraps, as guaranteed by ACC_W.
- DONE: sum_valid=1, in_ready=0. sum_out is held stable until the handshake. On the handshake edge, sum_valid <= 0 and state <= IDLE. sum_out keeps its last value afterwards.
- A start in the same cycle as the DONE handshake is ignored, because state is not yet IDLE. The next start is honoured one cycle later.
- busy = (state != IDLE).
- N_INPUTS=1: a single handshake moves ACCUM -> DONE.

Decomposition:
- Shared package perceptron_pkg:
  - DATA_W, FRAC_BITS, FIXED_ONE (32768)
  - state enum {IDLE, ACCUM, DONE}
  - sat_to_data function
  activation_function uses the same FIXED_ONE.
- One sub-module, fixed_mul: combinational signed DATA_W x DATA_W multiply with >>> FRAC_BITS, output width 2*DATA_W-FRAC_BITS. It is reused later for the weight-update stage.

Test Plan:
- Basic sum: bias=0, four pairs (32768, 32768). Required: sum_valid exactly 1 cycle after the 4th handshake, sum_out=131072 (4.0), busy low after the output handshake.
- Sign and bias: bias=16384. Pairs: (-32768, 16384), (0, 5), (0, 5), (0, 5). Required: sum_out=0. Second run: bias=0, pair (-1, 1) then three zero pairs. Required: sum_out=-1 (floor truncation). With (1, 1): sum_out=0.
- Saturation: four pairs (0x7FFFFFFF, 0x7FFFFFFF). Required: sum_out=0x7FFFFFFF. Four pairs (0x80000000, 0x7FFFFFFF). Required: sum_out=0x80000000.
- Handshake gaps and backpressure:
  - in_valid toggled 1-0-1-0 across 8 cycles: exactly 4 accepted.
  - sum_ready low 3 cycles: sum_out stable, in_ready=0, extra start ignored.
  - sum_ready high: sum_valid drops next cycle.
- Reset mid-operation: assert rst_n=0 after 2 accepted pairs. Required: next cycle all outputs 0 and state IDLE. A fresh start with 4 pairs (32768, 32768) then gives 131072, with no stale contribution.
- Start corner cases: start high together with in_valid in IDLE, then 4 pairs. Required: the start-cycle pair is not counted. start in the same cycle as the DONE handshake: no new evaluation begins and busy=0 the following cycle.

Source files
------------

// File: rtl/perceptron_pkg.sv
// Shared types, fixed-point constants and output saturation for the perceptron datapath.
package perceptron_pkg;

  localparam int DATA_W    = 32;
  localparam int FRAC_BITS = 15;
  localparam int FIXED_ONE = 1 << FRAC_BITS;
  localparam int ACC_W     = 56;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (DATA_W - 1));

  // Clamp a wide signed value into the DATA_W signed range.
  function automatic logic [DATA_W-1:0] sat_to_data(input logic signed [63:0] v);
    logic [DATA_W-1:0] r;
    if (v > SAT_MAX) begin
      r = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      r = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_mul.sv
// Combinational signed fixed-point multiply; the full product is shifted right
// arithmetically by FRAC_BITS, so the result rounds toward minus infinity.
module fixed_mul #(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 15
) (
  input  logic signed [DATA_W-1:0]           a_i,
  input  logic signed [DATA_W-1:0]           b_i,
  output logic signed [2*DATA_W-FRAC_BITS-1:0] p_o
);

  localparam int FULL_W = 2 * DATA_W;
  localparam int OUT_W  = 2 * DATA_W - FRAC_BITS;

  logic signed [FULL_W-1:0] full;

  assign full = FULL_W'(a_i) * FULL_W'(b_i);
  // Bits dropped by the cast are copies of the sign, so no information is lost.
  assign p_o  = OUT_W'(full >>> FRAC_BITS);

endmodule

// File: rtl/neuron_accumulator.sv
// Weighted-sum stage of the perceptron: bias + sum(x*w) over N_INPUTS pairs,
// saturated to DATA_W and handed downstream over valid/ready.
module neuron_accumulator #(
  parameter int N_INPUTS  = 4,
  parameter int DATA_W    = perceptron_pkg::DATA_W,
  parameter int FRAC_BITS = perceptron_pkg::FRAC_BITS,
  parameter int ACC_W     = perceptron_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] w_in,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [DATA_W-1:0] sum_out
);

  import perceptron_pkg::state_t;
  import perceptron_pkg::IDLE;
  import perceptron_pkg::ACCUM;
  import perceptron_pkg::DONE;
  import perceptron_pkg::sat_to_data;

  localparam int PROD_W = 2 * DATA_W - FRAC_BITS;
  localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

  state_t                   state_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic [CNT_W-1:0]         count_q;
  logic [DATA_W-1:0]        sum_q;
  logic                     sum_valid_q;
  logic signed [PROD_W-1:0] prod;

  fixed_mul #(
    .DATA_W   (DATA_W),
    .FRAC_BITS(FRAC_BITS)
  ) u_mul (
    .a_i(x_in),
    .b_i(w_in),
    .p_o(prod)
  );

  always_comb begin
    acc_d = acc_q + ACC_W'(prod);
  end

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign sum_valid = sum_valid_q;
  assign sum_out   = sum_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= ACC_W'($signed(bias));
            count_q <= '0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_q   <= acc_d;
            count_q <= count_q + CNT_W'(1);
            // The final pair goes straight to the output register, saving a cycle.
            if (count_q == LAST_IDX) begin
              sum_q       <= sat_to_data(64'(acc_d));
              sum_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (sum_ready) begin
            sum_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed self-checking bench for neuron_accumulator (N_INPUTS = 4, 17.15 data).
module tb_neuron_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] bias;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in;
  logic [31:0] w_in;
  logic        sum_valid;
  logic        sum_ready;
  logic [31:0] sum_out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  neuron_accumulator #(
    .N_INPUTS (4),
    .DATA_W   (32),
    .FRAC_BITS(15),
    .ACC_W    (56)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bias     (bias),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .w_in     (w_in),
    .sum_valid(sum_valid),
    .sum_ready(sum_ready),
    .sum_out  (sum_out)
  );

  typedef struct {
    string             name;
    logic [31:0]       bias;
    logic [3:0][31:0]  x;
    logic [3:0][31:0]  w;
    logic [31:0]       exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h (%0d), want 0x%08h (%0d)",
               name, act, $signed(act), exp, $signed(exp));
    end
  endtask

  function automatic logic [3:0][31:0] pk(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    logic [3:0][31:0] r;
    r[0] = a;
    r[1] = b;
    r[2] = c;
    r[3] = d;
    return r;
  endfunction

  // Drive start for one cycle, then four back-to-back pairs; checks 1-cycle output latency.
  task automatic run_eval(input vec_t v);
    @(negedge clk);
    start = 1'b1;
    bias  = v.bias;
    @(negedge clk);
    start = 1'b0;
    bias  = 32'h0;
    check({v.name, " busy after start"}, {31'b0, busy}, 32'd1);
    check({v.name, " in_ready in ACCUM"}, {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      x_in     = v.x[i];
      w_in     = v.w[i];
      @(negedge clk);
      if (i == 2) check({v.name, " no early valid"}, {31'b0, sum_valid}, 32'd0);
    end
    in_valid = 1'b0;
    x_in     = 32'h0;
    w_in     = 32'h0;
    check({v.name, " sum_valid"}, {31'b0, sum_valid}, 32'd1);
    check({v.name, " sum_out"}, sum_out, v.exp);
    check({v.name, " in_ready in DONE"}, {31'b0, in_ready}, 32'd0);
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    check({v.name, " valid drop"}, {31'b0, sum_valid}, 32'd0);
    check({v.name, " busy drop"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    rst_n = 1'b0; start = 1'b0; bias = '0; in_valid = 1'b0;
    x_in = '0; w_in = '0; sum_ready = 1'b0;

    vecs[0] = '{"basic", 32'd0, pk(32768, 32768, 32768, 32768),
                pk(32768, 32768, 32768, 32768), 32'd131072};
    vecs[1] = '{"sign_bias", 32'd16384, pk(32'hFFFF8000, 0, 0, 0),
                pk(16384, 5, 5, 5), 32'd0};
    vecs[2] = '{"floor_neg", 32'd0, pk(32'hFFFFFFFF, 0, 0, 0),
                pk(1, 0, 0, 0), 32'hFFFFFFFF};
    vecs[3] = '{"floor_pos", 32'd0, pk(1, 0, 0, 0), pk(1, 0, 0, 0), 32'd0};
    vecs[4] = '{"sat_pos", 32'd0,
                pk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
                pk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF), 32'h7FFFFFFF};
    vecs[5] = '{"sat_neg", 32'd0,
                pk(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000),
                pk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF), 32'h80000000};
    // 1.0 + 2*3 - 1*2 + 0.5*0.5 = 5.25
    vecs[6] = '{"mixed", 32'd32768, pk(65536, 32'hFFFF8000, 16384, 0),
                pk(98304, 65536, 16384, 0), 32'd172032};

    repeat (2) @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset in_ready", {31'b0, in_ready}, 32'd0);
    check("reset sum_valid", {31'b0, sum_valid}, 32'd0);
    check("reset sum_out", sum_out, 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) run_eval(vecs[k]);

    // Gapped input: only valid cycles are accepted.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c % 2 == 0);
      x_in     = (c % 2 == 0) ? 32'd32768 : 32'd12345678;
      w_in     = 32'd32768;
      @(negedge clk);
      if (c == 5) check("gap no early valid", {31'b0, sum_valid}, 32'd0);
    end
    in_valid = 1'b0;
    check("gap sum_valid", {31'b0, sum_valid}, 32'd1);
    check("gap sum_out", sum_out, 32'd131072);

    // Backpressure with a stray start that must be ignored.
    held  = sum_out;
    start = 1'b1;
    bias  = 32'd999;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp sum_out stable", sum_out, held);
      check("bp sum_valid held", {31'b0, sum_valid}, 32'd1);
      check("bp in_ready low", {31'b0, in_ready}, 32'd0);
    end
    // Start coincides with the output handshake: no new evaluation.
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    start     = 1'b0;
    check("hs start ignored busy", {31'b0, busy}, 32'd0);
    check("hs valid drop", {31'b0, sum_valid}, 32'd0);
    check("sum_out kept", sum_out, held);
    @(negedge clk);
    check("still idle", {31'b0, busy}, 32'd0);

    // Reset after two accepted pairs.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      x_in     = 32'd327680;
      w_in     = 32'd32768;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst busy", {31'b0, busy}, 32'd0);
    check("midrst in_ready", {31'b0, in_ready}, 32'd0);
    check("midrst sum_valid", {31'b0, sum_valid}, 32'd0);
    check("midrst sum_out", sum_out, 32'd0);
    run_eval(vecs[0]);

    // Pair offered together with start in IDLE must not be counted.
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    x_in     = 32'd327680;
    w_in     = 32'd32768;
    @(negedge clk);
    start = 1'b0;
    check("start pair busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      x_in = 32'd32768;
      w_in = 32'd32768;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("start pair valid", {31'b0, sum_valid}, 32'd1);
    check("start pair sum", sum_out, 32'd131072);
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    check("start pair done", {31'b0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule
